// File: rtl/mmio_timer_pkg.sv
// -----------------------------------------------------------------------------
// mmio_timer_pkg
//   Shared constants for the memory-mapped timer peripheral:
//     - RegWidth          : width of the CPU data-RAM buses
//     - TIMER_* offsets   : byte offsets of the timer registers in the window
//     - CTRL_* / STATUS_* : bit positions inside CTRL and STATUS
//     - byte_merge()      : byte-lane masked register update helper
// -----------------------------------------------------------------------------
package mmio_timer_pkg;

    localparam int unsigned RegWidth = 32;
    localparam int unsigned LaneCnt  = RegWidth / 8;

    typedef logic [RegWidth-1:0] word_t;
    typedef logic [LaneCnt-1:0]  lanes_t;

    // Register offsets within the 32-byte window (addr[4:0], low bits zero).
    localparam logic [4:0] TIMER_CTRL     = 5'h00;
    localparam logic [4:0] TIMER_COUNT    = 5'h04;
    localparam logic [4:0] TIMER_COMPARE  = 5'h08;
    localparam logic [4:0] TIMER_STATUS   = 5'h0C;
    localparam logic [4:0] TIMER_PRESCALE = 5'h10;

    // CTRL bit positions.
    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_IE   = 2;

    // STATUS bit positions.
    localparam int unsigned STATUS_MATCH = 0;

    // Replace the bytes of old_val whose lane bit is set with those of new_val.
    function automatic word_t byte_merge(
        input word_t  old_val,
        input word_t  new_val,
        input lanes_t sel
    );
        word_t res;
        res = old_val;
        for (int unsigned i = 0; i < LaneCnt; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//   Divides the clock down to a one-cycle tick for the timer count.
//   The internal counter runs 0..prescale while enabled and wraps to 0 on the
//   cycle it reaches prescale; that cycle is the tick. prescale = 0 therefore
//   ticks every enabled cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   count enable; when low the counter holds its value
//   prescale in   terminal value of the internal counter
//   clear    in   forces the counter to 0 and suppresses the tick this cycle
//   tick     out  one-cycle pulse at the terminal count
// -----------------------------------------------------------------------------
module timer_prescaler
    import mmio_timer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [RegWidth-1:0] prescale,
    input  logic                clear,
    output logic                tick
);

    logic [RegWidth-1:0] r_pcnt;
    logic                w_terminal;

    assign w_terminal = (r_pcnt == prescale);

    // A clear (software PRESCALE access) restarts the period, so the tick that
    // would otherwise fire on this edge is dropped.
    assign tick = en && w_terminal && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
        end else if (clear) begin
            r_pcnt <= '0;
        end else if (en) begin
            r_pcnt <= w_terminal ? '0 : r_pcnt + word_t'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
//   Timer peripheral answering the CPU data-RAM port beside data_ram.
//   Provides a prescaled 32-bit up-counter, a compare match with optional
//   auto-reload and a level interrupt. Reads have the same one-cycle latency
//   as data_ram.
//
//   Register window at BASE_ADDR (addr[4:2] selects):
//     0x00 CTRL     [0] EN, [1] AUTO, [2] IE
//     0x04 COUNT    32-bit counter
//     0x08 COMPARE  32-bit compare value
//     0x0C STATUS   [0] MATCH, write-1-to-clear
//     0x10 PRESCALE 32-bit prescaler terminal value
//     0x14-0x1C     reserved, read 0, writes dropped
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   ram_en   in   request valid
//   write_en in   1 = write, 0 = read
//   addr     in   byte address, [1:0] ignored
//   select   in   byte-lane write enables
//   data_i   in   write data
//   data_o   out  registered read data, held between read hits
//   irq_o    out  MATCH & IE
// -----------------------------------------------------------------------------
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [RegWidth-1:0] BASE_ADDR = 32'h1FD0_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ram_en,
    input  logic                write_en,
    input  logic [RegWidth-1:0] addr,
    input  logic [LaneCnt-1:0]  select,
    input  logic [RegWidth-1:0] data_i,
    output logic [RegWidth-1:0] data_o,
    output logic                irq_o
);

    // -------------------------------------------------------------------------
    // Register state
    // -------------------------------------------------------------------------
    logic [2:0]          r_ctrl;
    logic [RegWidth-1:0] r_count;
    logic [RegWidth-1:0] r_compare;
    logic                r_match;
    logic [RegWidth-1:0] r_prescale;
    logic [RegWidth-1:0] r_data;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic       w_hit;
    logic       w_wr;
    logic       w_rd;
    logic [4:0] w_off;
    logic       w_any_lane;
    logic       w_wr_ctrl;
    logic       w_wr_count;
    logic       w_wr_compare;
    logic       w_wr_status;
    logic       w_wr_prescale;
    logic       w_unused_addr;

    assign w_hit      = ram_en && (addr[RegWidth-1:5] == BASE_ADDR[RegWidth-1:5]);
    assign w_wr       = w_hit && write_en;
    assign w_rd       = w_hit && !write_en;
    assign w_off      = {addr[4:2], 2'b00};
    assign w_any_lane = |select;

    assign w_wr_ctrl     = w_wr && (w_off == TIMER_CTRL);
    assign w_wr_count    = w_wr && (w_off == TIMER_COUNT);
    assign w_wr_compare  = w_wr && (w_off == TIMER_COMPARE);
    assign w_wr_status   = w_wr && (w_off == TIMER_STATUS);
    assign w_wr_prescale = w_wr && (w_off == TIMER_PRESCALE);

    // Word-aligned port: the byte offset bits carry no information.
    assign w_unused_addr = ^addr[1:0];

    // -------------------------------------------------------------------------
    // Prescaler
    // -------------------------------------------------------------------------
    logic w_tick;

    // Any write to PRESCALE restarts the period, even with no lanes selected.
    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (r_ctrl[CTRL_EN]),
        .prescale (r_prescale),
        .clear    (w_wr_prescale),
        .tick     (w_tick)
    );

    // -------------------------------------------------------------------------
    // Count / match
    // -------------------------------------------------------------------------
    logic                w_cnt_sw;
    logic                w_tick_cnt;
    logic                w_eq;
    logic                w_match_set;
    logic                w_match_clr;
    logic [RegWidth-1:0] w_count_tick;

    // A software COUNT write that actually changes bytes owns the edge: the
    // tick is discarded and no compare is evaluated against the old value.
    assign w_cnt_sw    = w_wr_count && w_any_lane;
    assign w_tick_cnt  = w_tick && !w_cnt_sw;
    assign w_eq        = (r_count == r_compare);
    assign w_match_set = w_tick_cnt && w_eq;
    assign w_match_clr = w_wr_status && select[0] && data_i[STATUS_MATCH];

    // 0xFFFF_FFFF + 1 wraps naturally to 0; only equality sets MATCH.
    assign w_count_tick = (w_eq && r_ctrl[CTRL_AUTO]) ? '0 : r_count + word_t'(1);

    // -------------------------------------------------------------------------
    // Read mux (pre-update register values)
    // -------------------------------------------------------------------------
    logic [RegWidth-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            TIMER_CTRL: begin
                w_rdata[CTRL_EN]   = r_ctrl[CTRL_EN];
                w_rdata[CTRL_AUTO] = r_ctrl[CTRL_AUTO];
                w_rdata[CTRL_IE]   = r_ctrl[CTRL_IE];
            end
            TIMER_COUNT:    w_rdata = r_count;
            TIMER_COMPARE:  w_rdata = r_compare;
            TIMER_STATUS:   w_rdata[STATUS_MATCH] = r_match;
            TIMER_PRESCALE: w_rdata = r_prescale;
            default:        w_rdata = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Register update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl     <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
            r_prescale <= '0;
            r_data     <= '0;
        end else begin
            // CTRL only has bits in lane 0.
            if (w_wr_ctrl && select[0]) begin
                r_ctrl[CTRL_EN]   <= data_i[CTRL_EN];
                r_ctrl[CTRL_AUTO] <= data_i[CTRL_AUTO];
                r_ctrl[CTRL_IE]   <= data_i[CTRL_IE];
            end

            if (w_wr_compare) begin
                r_compare <= byte_merge(r_compare, data_i, select);
            end

            if (w_wr_prescale) begin
                r_prescale <= byte_merge(r_prescale, data_i, select);
            end

            if (w_cnt_sw) begin
                r_count <= byte_merge(r_count, data_i, select);
            end else if (w_tick_cnt) begin
                r_count <= w_count_tick;
            end

            // A match raised by the hardware wins over a same-edge W1C.
            if (w_match_set) begin
                r_match <= 1'b1;
            end else if (w_match_clr) begin
                r_match <= 1'b0;
            end

            if (w_rd) begin
                r_data <= w_rdata;
            end
        end
    end

    assign data_o = r_data;
    assign irq_o  = r_match && r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h1FD0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic        write_en;
    logic [31:0] addr;
    logic [3:0]  select;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .ram_en   (ram_en),
        .write_en (write_en),
        .addr     (addr),
        .select   (select),
        .data_i   (data_i),
        .data_o   (data_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: architectural register values plus "enabled cycles
    // since the prescale period started".
    // ---------------------------------------------------------------------
    logic        m_en, m_auto, m_ie, m_match;
    logic [31:0] m_count, m_compare, m_prescale, m_data, m_since;

    function automatic logic m_irq();
        return m_match & m_ie;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_reg(input logic [4:0] off);
        case (off)
            5'h00:   return {29'd0, m_ie, m_auto, m_en};
            5'h04:   return m_count;
            5'h08:   return m_compare;
            5'h0C:   return {31'd0, m_match};
            5'h10:   return m_prescale;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_match = 0;
        m_count = 0; m_compare = 0; m_prescale = 0; m_data = 0; m_since = 0;
    endtask

    // Drive one bus cycle, advance the model by one clock, sample at edge+1.
    task automatic cyc(input logic en, input logic we, input logic [31:0] a,
                       input logic [3:0] sel, input logic [31:0] d);
        logic       hit, wr, tick, same, sw_cnt, pre_wr;
        logic [4:0] off;
        ram_en = en; write_en = we; addr = a; select = sel; data_i = d;
        hit    = en && (a[31:5] == BASE[31:5]);
        wr     = hit && we;
        off    = {a[4:2], 2'b00};
        pre_wr = wr && (off == 5'h10);
        sw_cnt = wr && (off == 5'h04) && (sel != 4'd0);
        if (hit && !we) m_data = m_reg(off);
        tick = m_en && !pre_wr && (m_since == m_prescale);
        same = (m_count == m_compare);
        if (pre_wr)     m_since = 0;
        else if (m_en)  m_since = tick ? 32'd0 : m_since + 1;
        if (sw_cnt) begin
            m_count = m_merge(m_count, d, sel);
        end else if (tick) begin
            if (same && m_auto) m_count = 0;
            else                m_count = m_count + 1;
        end
        if (tick && !sw_cnt && same)                      m_match = 1;
        else if (wr && off == 5'h0C && sel[0] && d[0])    m_match = 0;
        if (wr && off == 5'h00 && sel[0]) {m_ie, m_auto, m_en} = d[2:0];
        if (wr && off == 5'h08) m_compare  = m_merge(m_compare, d, sel);
        if (pre_wr)             m_prescale = m_merge(m_prescale, d, sel);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] off, input logic [3:0] sel, input logic [31:0] d);
        cyc(1'b1, 1'b1, BASE + {27'd0, off}, sel, d);
    endtask

    task automatic rd_reg(input logic [4:0] off);
        cyc(1'b1, 1'b0, BASE + {27'd0, off}, 4'($urandom), $urandom);
    endtask

    task automatic idle();
        cyc(1'b0, 1'($urandom), BASE + 32'($urandom_range(0, 31)), 4'($urandom), $urandom);
    endtask

    task automatic do_reset();
        ram_en = 0;
        rst = 0;
        m_reset();
        @(negedge clk);
        rst = 1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        wr_reg(5'h10, 4'hF, 32'd0);
        wr_reg(5'h08, 4'hF, 32'h55);
        wr_reg(5'h04, 4'hF, 32'h55);
        wr_reg(5'h00, 4'hF, 32'h5);
        rd_reg(5'h04);
        n_checks++;
        if (data_o !== m_data || data_o !== 32'h55) begin
            n_fail++; $display("FAIL pre_reset_count: got %h expected %h", data_o, 32'h55);
        end
        n_checks++;
        if (irq_o !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq_o);
        end
        #2 rst = 0;
        #1;
        m_reset();
        n_checks++;
        if (data_o !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_data: got %h expected 0", data_o);
        end
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_irq: got %b expected 0", irq_o);
        end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 8; i++) begin
            rd_reg(5'(i * 4));
            n_checks++;
            if (data_o !== 32'd0) begin
                n_fail++; $display("FAIL reset_reg_%0d: got %h expected 0", i, data_o);
            end
        end
    endtask

    task automatic test_count_match();
        logic seen;
        seen = 0;
        do_reset();
        wr_reg(5'h10, 4'hF, 32'd2);
        wr_reg(5'h08, 4'hF, 32'd3);
        wr_reg(5'h00, 4'hF, 32'h5);
        for (int i = 0; i < 40 && !seen; i++) begin
            rd_reg(5'h04);
            n_checks++;
            if (data_o !== m_data || irq_o !== m_irq()) begin
                n_fail++;
                $display("FAIL count_step_%0d: got data %h irq %b expected data %h irq %b",
                         i, data_o, irq_o, m_data, m_irq());
            end
            seen = irq_o;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL match_irq_timeout: got irq 0 expected 1 within 40 cycles");
        end
        rd_reg(5'h04);
        n_checks++;
        if (data_o !== 32'd4) begin
            n_fail++; $display("FAIL count_after_match: got %h expected 4", data_o);
        end
        rd_reg(5'h0C);
        n_checks++;
        if (data_o !== 32'd1) begin
            n_fail++; $display("FAIL match_status: got %h expected 1", data_o);
        end
    endtask

    task automatic test_auto_reload();
        do_reset();
        wr_reg(5'h10, 4'hF, 32'd0);
        wr_reg(5'h08, 4'hF, 32'd1);
        wr_reg(5'h00, 4'hF, 32'h3);
        for (int i = 0; i < 8; i++) begin
            rd_reg(5'h04);
            n_checks++;
            if (data_o !== 32'(i % 2) || irq_o !== 1'b0) begin
                n_fail++;
                $display("FAIL auto_reload_%0d: got count %h irq %b expected count %h irq 0",
                         i, data_o, irq_o, 32'(i % 2));
            end
        end
        for (int i = 0; i < 4 && m_count != 0; i++) idle();
        wr_reg(5'h0C, 4'h1, 32'h1);
        rd_reg(5'h0C);
        n_checks++;
        if (data_o !== 32'd0 || data_o !== m_data) begin
            n_fail++; $display("FAIL w1c_clear: got %h expected 0", data_o);
        end
        rd_reg(5'h0C);
        n_checks++;
        if (data_o !== m_data || irq_o !== 1'b0) begin
            n_fail++; $display("FAIL w1c_reset_again: got %h irq %b expected %h irq 0",
                               data_o, irq_o, m_data);
        end
    endtask

    task automatic test_byte_lanes();
        logic [4:0] off;
        logic [4:0] offs [3];
        offs[0] = 5'h04; offs[1] = 5'h08; offs[2] = 5'h10;
        do_reset();
        wr_reg(5'h08, 4'b0101, 32'hAABBCCDD);
        rd_reg(5'h08);
        n_checks++;
        if (data_o !== 32'h00BB00DD) begin
            n_fail++; $display("FAIL lane_merge: got %h expected %h", data_o, 32'h00BB00DD);
        end
        cyc(1'b1, 1'b1, BASE + 32'h20, 4'hF, 32'h12345678);
        cyc(1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'h0);
        n_checks++;
        if (data_o !== 32'h00BB00DD) begin
            n_fail++; $display("FAIL non_hit_hold: got %h expected %h", data_o, 32'h00BB00DD);
        end
        for (int i = 0; i < 8; i++) begin
            rd_reg(5'(i * 4));
            n_checks++;
            if (data_o !== m_data) begin
                n_fail++; $display("FAIL non_hit_regs_%0d: got %h expected %h", i, data_o, m_data);
            end
        end
        for (int i = 0; i < 12; i++) begin
            off = offs[$urandom_range(0, 2)];
            wr_reg(off, 4'($urandom), $urandom);
            rd_reg(off);
            n_checks++;
            if (data_o !== m_data) begin
                n_fail++; $display("FAIL lane_rand_%0d: got %h expected %h", i, data_o, m_data);
            end
        end
    endtask

    task automatic test_collisions();
        do_reset();
        wr_reg(5'h10, 4'hF, 32'd1);
        wr_reg(5'h08, 4'hF, 32'd7);
        wr_reg(5'h04, 4'hF, 32'd7);
        wr_reg(5'h00, 4'hF, 32'h1);
        idle();
        wr_reg(5'h04, 4'hF, 32'h10);
        rd_reg(5'h04);
        n_checks++;
        if (data_o !== 32'h10 || data_o !== m_data) begin
            n_fail++; $display("FAIL sw_count_wins: got %h expected %h", data_o, 32'h10);
        end
        rd_reg(5'h0C);
        n_checks++;
        if (data_o !== 32'd0) begin
            n_fail++; $display("FAIL sw_count_no_match: got %h expected 0", data_o);
        end
        do_reset();
        wr_reg(5'h10, 4'hF, 32'd1);
        wr_reg(5'h08, 4'hF, 32'd7);
        wr_reg(5'h04, 4'hF, 32'd7);
        wr_reg(5'h00, 4'hF, 32'h1);
        idle();
        wr_reg(5'h0C, 4'hF, 32'h1);
        rd_reg(5'h0C);
        n_checks++;
        if (data_o !== 32'd1 || irq_o !== 1'b0) begin
            n_fail++; $display("FAIL set_beats_w1c: got %h irq %b expected 1 irq 0", data_o, irq_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wr_reg(5'h10, 4'hF, 32'd0);
        wr_reg(5'h08, 4'hF, 32'd5);
        wr_reg(5'h04, 4'hF, 32'hFFFF_FFFF);
        wr_reg(5'h00, 4'hF, 32'h1);
        wr_reg(5'h00, 4'hF, 32'h0);
        rd_reg(5'h04);
        n_checks++;
        if (data_o !== 32'd0) begin
            n_fail++; $display("FAIL wrap_count: got %h expected 0", data_o);
        end
        rd_reg(5'h0C);
        n_checks++;
        if (data_o !== 32'd0) begin
            n_fail++; $display("FAIL wrap_no_match: got %h expected 0", data_o);
        end
        rd_reg(5'h04);
        n_checks++;
        if (data_o !== 32'd0) begin
            n_fail++; $display("FAIL freeze_count: got %h expected 0", data_o);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned op;
        logic [4:0]  off;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            op  = $urandom_range(0, 9);
            off = {3'($urandom_range(0, 7)), 2'b00};
            case (off)
                5'h04, 5'h08: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                                              : 32'($urandom_range(0, 6));
                5'h10:        d = 32'($urandom_range(0, 3));
                default:      d = $urandom;
            endcase
            if (op <= 1)      idle();
            else if (op == 2) cyc(1'b1, 1'($urandom), BASE + 32'h20 * 32'($urandom_range(1, 1000)),
                                  4'($urandom), $urandom);
            else if (op <= 5) cyc(1'b1, 1'b0, BASE + {27'd0, off} + 32'($urandom_range(0, 3)),
                                  4'($urandom), $urandom);
            else              cyc(1'b1, 1'b1, BASE + {27'd0, off} + 32'($urandom_range(0, 3)),
                                  4'($urandom), d);
            n_checks++;
            if (data_o !== m_data || irq_o !== m_irq()) begin
                n_fail++;
                $display("FAIL b2b_%0d: got data %h irq %b expected data %h irq %b",
                         i, data_o, irq_o, m_data, m_irq());
            end
        end
    endtask

    initial begin
        rst = 0; ram_en = 0; write_en = 0; addr = 0; select = 0; data_i = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_count_match();
        test_auto_reload();
        test_byte_lanes();
        test_collisions();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
